// File: rtl/sensor_a2d_sched.sv
// sensor_a2d_sched: round-robin A2D scheduler that shares one SPI master
// between the battery, current, brake and torque channels. Each channel
// runs a command transaction followed by a read transaction over the
// wrt/done handshake. The 12-bit result is kept per channel, and
// conv_cmplt pulses once at the end of every full round.
//
// Optional feature: define A2D_WDOG_EN to add a 1023-cycle watchdog on the
// SPI wait states. It aborts a stalled channel and sets the sticky timeout
// flag. With A2D_WDOG_EN undefined the FSM waits for done indefinitely and
// timeout is tied low.
module sensor_a2d_sched #(
    parameter int         FAST_SIM  = 1,
    parameter logic [2:0] CH_BATT   = 3'd0,
    parameter logic [2:0] CH_CURR   = 3'd1,
    parameter logic [2:0] CH_BRAKE  = 3'd3,
    parameter logic [2:0] CH_TORQUE = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] wt_data,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        conv_cmplt,
    output logic        all_valid,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WAIT_CMD = 3'd2,
        GAP      = 3'd3,
        READ     = 3'd4,
        WAIT_RD  = 3'd5
    } state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [13:0] tmr_q;
    logic [13:0] tmr_d;
    logic        tmr_tc;
    logic        wrt_q;
    logic [15:0] wt_data_q;
    logic [11:0] batt_q;
    logic [11:0] curr_q;
    logic [11:0] brake_q;
    logic [11:0] torque_q;
    logic [3:0]  stored_q;
    logic        tstore_q;
    logic        conv_q;
    logic        all_valid_q;

`ifdef A2D_WDOG_EN
    logic [9:0]  wdog_q;
    logic        timeout_q;
    logic        wdog_exp;
`endif

    // Only the low 12 bits of a read carry the conversion result.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

    // Command word for the channel selected by the round-robin index.
    function automatic logic [15:0] cmd_word(input logic [1:0] idx);
        case (idx)
            2'd0:    cmd_word = {2'b00, CH_BATT,   11'h000};
            2'd1:    cmd_word = {2'b00, CH_CURR,   11'h000};
            2'd2:    cmd_word = {2'b00, CH_BRAKE,  11'h000};
            default: cmd_word = {2'b00, CH_TORQUE, 11'h000};
        endcase
    endfunction

    // The short terminal count keeps simulations fast; silicon uses the full 14 bits.
    assign tmr_tc = (FAST_SIM != 0) ? (&tmr_q[8:0]) : (&tmr_q[13:0]);

    // Inter-conversion timer: runs only while idle and enabled, otherwise parked at zero.
    always_comb begin
        tmr_d = 14'd0;
        if (state_q == IDLE && en) begin
            tmr_d = tmr_tc ? 14'd0 : (tmr_q + 14'd1);
        end
    end

`ifdef A2D_WDOG_EN
    assign wdog_exp = (wdog_q == 10'h3FF) && !done;
`endif

    // Scheduler FSM with registered wrt/wt_data, sample registers and round flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            tmr_q       <= 14'd0;
            wrt_q       <= 1'b0;
            wt_data_q   <= 16'h0000;
            batt_q      <= 12'h000;
            curr_q      <= 12'h000;
            brake_q     <= 12'h000;
            torque_q    <= 12'h000;
            stored_q    <= 4'b0000;
            tstore_q    <= 1'b0;
            conv_q      <= 1'b0;
            all_valid_q <= 1'b0;
`ifdef A2D_WDOG_EN
            wdog_q      <= 10'd0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            tmr_q       <= tmr_d;
            wrt_q       <= 1'b0;
            tstore_q    <= 1'b0;
            // conv_cmplt trails the torque store by one cycle so all four registers are settled.
            conv_q      <= tstore_q;
            all_valid_q <= all_valid_q | (tstore_q & (&stored_q));
            case (state_q)
                IDLE: begin
                    if (en && tmr_tc) begin
                        state_q   <= CMD;
                        wrt_q     <= 1'b1;
                        wt_data_q <= cmd_word(idx_q);
                    end
                end
                CMD: begin
                    state_q <= WAIT_CMD;
`ifdef A2D_WDOG_EN
                    wdog_q  <= 10'd0;
`endif
                end
                WAIT_CMD: begin
                    if (done) begin
                        state_q <= GAP;
                    end
`ifdef A2D_WDOG_EN
                    else if (wdog_exp) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                        idx_q     <= idx_q + 2'd1;
                    end else begin
                        wdog_q <= wdog_q + 10'd1;
                    end
`endif
                end
                GAP: begin
                    state_q <= READ;
                    wrt_q   <= 1'b1;
                end
                READ: begin
                    state_q <= WAIT_RD;
`ifdef A2D_WDOG_EN
                    wdog_q  <= 10'd0;
`endif
                end
                WAIT_RD: begin
                    if (done) begin
                        state_q         <= IDLE;
                        idx_q           <= idx_q + 2'd1;
                        stored_q[idx_q] <= 1'b1;
                        case (idx_q)
                            2'd0:    batt_q  <= rd_data[11:0];
                            2'd1:    curr_q  <= rd_data[11:0];
                            2'd2:    brake_q <= rd_data[11:0];
                            default: begin
                                torque_q <= rd_data[11:0];
                                tstore_q <= 1'b1;
                            end
                        endcase
                    end
`ifdef A2D_WDOG_EN
                    else if (wdog_exp) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                        idx_q     <= idx_q + 2'd1;
                    end else begin
                        wdog_q <= wdog_q + 10'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wrt        = wrt_q;
    assign wt_data    = wt_data_q;
    assign batt       = batt_q;
    assign curr       = curr_q;
    assign brake      = brake_q;
    assign torque     = torque_q;
    assign conv_cmplt = conv_q;
    assign all_valid  = all_valid_q;
`ifdef A2D_WDOG_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_a2d_sched.sv
// Bench for sensor_a2d_sched: SPI responder model plus a scoreboard of
// expected command words and channel results, checked per scenario.
module tb_sensor_a2d_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        done;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] wt_data;
    logic [11:0] batt, curr, brake, torque;
    logic        conv_cmplt, all_valid, timeout;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct {
        logic [15:0] cmd;
        logic [1:0]  ch;
        logic [11:0] val;
    } exp_t;
    exp_t sb_q[$];

    // SPI responder state
    logic [15:0] resp_data [8];
    bit          resp_drop [8];
    bit          resp_dbl  = 1'b0;
    int          resp_dly  = 20;
    int          r_cnt     = 0;
    int          r_hold    = 0;
    logic [2:0]  r_ch      = 3'd0;
    logic        done_r    = 1'b0;
    logic        spur      = 1'b0;
    int          wrt_cnt   = 0;
    int          conv_cnt  = 0;

    assign done = done_r | spur;

    always #5 clk = ~clk;

    sensor_a2d_sched #(.FAST_SIM(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .done       (done),
        .rd_data    (rd_data),
        .wrt        (wrt),
        .wt_data    (wt_data),
        .batt       (batt),
        .curr       (curr),
        .brake      (brake),
        .torque     (torque),
        .conv_cmplt (conv_cmplt),
        .all_valid  (all_valid),
        .timeout    (timeout)
    );

    // SPI master model: done pulse resp_dly cycles after each wrt, data by channel address
    always @(negedge clk) begin
        if (r_hold > 0) begin
            r_hold = r_hold - 1;
            if (r_hold == 0) begin
                done_r  = 1'b0;
                rd_data = 16'h0000;
            end
        end
        if (r_cnt > 0) begin
            r_cnt = r_cnt - 1;
            if (r_cnt == 0) begin
                done_r  = 1'b1;
                rd_data = resp_data[r_ch];
                r_hold  = resp_dbl ? 2 : 1;
            end
        end
        if (wrt === 1'b1 && !resp_drop[wt_data[13:11]]) begin
            r_ch  = wt_data[13:11];
            r_cnt = resp_dly;
        end
    end

    // Event counters for wrt pulses and conv_cmplt pulses
    always @(negedge clk) begin
        if (wrt === 1'b1) wrt_cnt = wrt_cnt + 1;
        if (conv_cmplt === 1'b1) conv_cnt = conv_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_wrt(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (wrt !== 1'b1 && n < bound);
    endtask

    function automatic logic [11:0] ch_reg(input logic [1:0] ch);
        case (ch)
            2'd0:    ch_reg = batt;
            2'd1:    ch_reg = curr;
            2'd2:    ch_reg = brake;
            default: ch_reg = torque;
        endcase
    endfunction

    task automatic wait_reg(input logic [1:0] ch, input logic [11:0] val, input int bound);
        int n;
        n = 0;
        while (ch_reg(ch) !== val && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        chk_cnt++; if (wrt !== 1'b0) $display("FAIL reset_wrt: got %b want 0", wrt); else pass_cnt++;
        chk_cnt++; if (wt_data !== 16'h0000) $display("FAIL reset_wt_data: got %h want 0000", wt_data); else pass_cnt++;
        chk_cnt++; if (batt !== 12'h000) $display("FAIL reset_batt: got %h want 000", batt); else pass_cnt++;
        chk_cnt++; if (curr !== 12'h000) $display("FAIL reset_curr: got %h want 000", curr); else pass_cnt++;
        chk_cnt++; if (brake !== 12'h000) $display("FAIL reset_brake: got %h want 000", brake); else pass_cnt++;
        chk_cnt++; if (torque !== 12'h000) $display("FAIL reset_torque: got %h want 000", torque); else pass_cnt++;
        chk_cnt++; if (conv_cmplt !== 1'b0) $display("FAIL reset_conv: got %b want 0", conv_cmplt); else pass_cnt++;
        chk_cnt++; if (all_valid !== 1'b0) $display("FAIL reset_all_valid: got %b want 0", all_valid); else pass_cnt++;
        chk_cnt++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else pass_cnt++;
    endtask

    task automatic test_first_conv();
        int   n;
        int   w0;
        exp_t e;
        resp_data[0] = 16'hFABC;
        sb_q.push_back('{cmd: 16'h0000, ch: 2'd0, val: 12'hABC});
        rst = 1'b0;
        wait_wrt(600, n);
        e = sb_q.pop_front();
        chk_cnt++; if (wrt !== 1'b1 || n != 512) $display("FAIL first_wrt_cycle: got %0d (wrt=%b) want 512", n, wrt); else pass_cnt++;
        chk_cnt++; if (wt_data !== e.cmd) $display("FAIL first_cmd: got %h want %h", wt_data, e.cmd); else pass_cnt++;
        w0 = wrt_cnt;
        wait_wrt(100, n);
        chk_cnt++; if (wrt !== 1'b1 || wt_data !== e.cmd) $display("FAIL first_read_cmd: got %h (wrt=%b) want %h", wt_data, wrt, e.cmd); else pass_cnt++;
        wait_reg(e.ch, e.val, 100);
        chk_cnt++; if (batt !== e.val) $display("FAIL first_batt: got %h want %h", batt, e.val); else pass_cnt++;
        chk_cnt++; if ({curr, brake, torque} !== 36'h0) $display("FAIL first_others: got %h %h %h want 000", curr, brake, torque); else pass_cnt++;
        chk_cnt++; if (wrt_cnt - w0 != 1) $display("FAIL first_read_wrts: got %0d want 1", wrt_cnt - w0); else pass_cnt++;
    endtask

    task automatic test_full_round();
        int   n;
        int   w0;
        int   c0;
        exp_t e;
        resp_data[0] = 16'h7111;
        resp_data[1] = 16'hC222;
        resp_data[3] = 16'h5333;
        resp_data[4] = 16'h9444;
        chk_cnt++; if (all_valid !== 1'b0) $display("FAIL round_all_valid_early: got %b want 0", all_valid); else pass_cnt++;
        c0 = conv_cnt;
        sb_q.push_back('{cmd: 16'h0800, ch: 2'd1, val: 12'h222});
        sb_q.push_back('{cmd: 16'h1800, ch: 2'd2, val: 12'h333});
        sb_q.push_back('{cmd: 16'h2000, ch: 2'd3, val: 12'h444});
        sb_q.push_back('{cmd: 16'h0000, ch: 2'd0, val: 12'h111});
        while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            w0 = wrt_cnt;
            wait_wrt(700, n);
            chk_cnt++; if (wrt !== 1'b1 || wt_data !== e.cmd) $display("FAIL round_cmd: got %h (wrt=%b) want %h", wt_data, wrt, e.cmd); else pass_cnt++;
            wait_wrt(100, n);
            chk_cnt++; if (wrt !== 1'b1 || wt_data !== e.cmd) $display("FAIL round_read_cmd: got %h (wrt=%b) want %h", wt_data, wrt, e.cmd); else pass_cnt++;
            wait_reg(e.ch, e.val, 100);
            chk_cnt++; if (ch_reg(e.ch) !== e.val) $display("FAIL round_result ch%0d: got %h want %h", e.ch, ch_reg(e.ch), e.val); else pass_cnt++;
            chk_cnt++; if (wrt_cnt - w0 != 2) $display("FAIL round_wrt_count: got %0d want 2", wrt_cnt - w0); else pass_cnt++;
            if (e.ch == 2'd3) begin
                chk_cnt++; if (conv_cmplt !== 1'b0) $display("FAIL conv_early: got %b want 0", conv_cmplt); else pass_cnt++;
                tick();
                chk_cnt++; if (conv_cmplt !== 1'b1) $display("FAIL conv_pulse: got %b want 1", conv_cmplt); else pass_cnt++;
                chk_cnt++; if (all_valid !== 1'b1) $display("FAIL all_valid_set: got %b want 1", all_valid); else pass_cnt++;
                tick();
                chk_cnt++; if (conv_cmplt !== 1'b0) $display("FAIL conv_width: got %b want 0", conv_cmplt); else pass_cnt++;
            end
        end
        chk_cnt++; if (conv_cnt - c0 != 1) $display("FAIL round_conv_count: got %0d want 1", conv_cnt - c0); else pass_cnt++;
        chk_cnt++; if (all_valid !== 1'b1) $display("FAIL all_valid_sticky: got %b want 1", all_valid); else pass_cnt++;
    endtask

    task automatic test_en_drop();
        int n;
        int w0;
        resp_data[1] = 16'h0555;
        wait_wrt(700, n);
        chk_cnt++; if (wrt !== 1'b1 || wt_data !== 16'h0800) $display("FAIL endrop_cmd: got %h want 0800", wt_data); else pass_cnt++;
        wait_wrt(100, n);
        repeat (5) tick();
        en = 1'b0;
        wait_reg(2'd1, 12'h555, 100);
        chk_cnt++; if (curr !== 12'h555) $display("FAIL endrop_curr: got %h want 555", curr); else pass_cnt++;
        w0 = wrt_cnt;
        repeat (1000) tick();
        chk_cnt++; if (wrt_cnt != w0) $display("FAIL endrop_no_wrt: got %0d want 0", wrt_cnt - w0); else pass_cnt++;
        en = 1'b1;
        wait_wrt(600, n);
        chk_cnt++; if (wrt !== 1'b1 || n != 512) $display("FAIL endrop_resume_cycle: got %0d want 512", n); else pass_cnt++;
        chk_cnt++; if (wt_data !== 16'h1800) $display("FAIL endrop_resume_cmd: got %h want 1800", wt_data); else pass_cnt++;
        wait_wrt(100, n);
        wait_reg(2'd2, 12'h333, 100);
        chk_cnt++; if (brake !== 12'h333) $display("FAIL endrop_brake: got %h want 333", brake); else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        int n;
        bit found;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            wait_wrt(700, n);
            if (wrt === 1'b1 && wt_data === 16'h1800) found = 1'b1;
        end
        chk_cnt++; if (!found) $display("FAIL rstmid_brake_cmd: got %h want 1800", wt_data); else pass_cnt++;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk_cnt++; if ({batt, curr, brake, torque} !== 48'h0) $display("FAIL rstmid_regs: got %h %h %h %h want 000", batt, curr, brake, torque); else pass_cnt++;
        tick();
        rst = 1'b0;
        chk_cnt++; if (wt_data !== 16'h0000 || wrt !== 1'b0) $display("FAIL rstmid_wt: got %h wrt=%b want 0000/0", wt_data, wrt); else pass_cnt++;
        chk_cnt++; if (all_valid !== 1'b0) $display("FAIL rstmid_all_valid: got %b want 0", all_valid); else pass_cnt++;
        wait_wrt(600, n);
        chk_cnt++; if (wrt !== 1'b1 || n != 512) $display("FAIL rstmid_next_cycle: got %0d want 512", n); else pass_cnt++;
        chk_cnt++; if (wt_data !== 16'h0000) $display("FAIL rstmid_next_cmd: got %h want 0000", wt_data); else pass_cnt++;
        chk_cnt++; if (brake !== 12'h000) $display("FAIL rstmid_brake_held: got %h want 000", brake); else pass_cnt++;
        wait_wrt(100, n);
        wait_reg(2'd0, 12'h111, 100);
        chk_cnt++; if (batt !== 12'h111) $display("FAIL rstmid_batt: got %h want 111", batt); else pass_cnt++;
    endtask

    task automatic test_spurious();
        int n;
        int w0;
        resp_data[1] = 16'h0666;
        w0 = wrt_cnt;
        repeat (10) tick();
        for (int k = 0; k < 3; k++) begin
            spur = 1'b1;
            tick();
            spur = 1'b0;
            repeat (20) tick();
        end
        chk_cnt++; if (wrt_cnt != w0) $display("FAIL spur_idle_wrt: got %0d want 0", wrt_cnt - w0); else pass_cnt++;
        chk_cnt++; if (batt !== 12'h111 || curr !== 12'h000) $display("FAIL spur_idle_regs: got %h %h want 111 000", batt, curr); else pass_cnt++;
        resp_dbl = 1'b1;
        wait_wrt(700, n);
        chk_cnt++; if (wrt !== 1'b1 || wt_data !== 16'h0800) $display("FAIL spur_cmd: got %h want 0800", wt_data); else pass_cnt++;
        wait_reg(2'd1, 12'h666, 200);
        chk_cnt++; if (curr !== 12'h666) $display("FAIL spur_curr: got %h want 666", curr); else pass_cnt++;
        repeat (5) tick();
        chk_cnt++; if (wrt_cnt - w0 != 2) $display("FAIL spur_gap_wrts: got %0d want 2", wrt_cnt - w0); else pass_cnt++;
        chk_cnt++; if (batt !== 12'h111 || brake !== 12'h000) $display("FAIL spur_hold: got %h %h want 111 000", batt, brake); else pass_cnt++;
        resp_dbl = 1'b0;
    endtask

    task automatic test_watchdog();
`ifdef A2D_WDOG_EN
        int n;
        int c0;
        wait_wrt(700, n);
        wait_wrt(100, n);
        wait_reg(2'd2, 12'h333, 100);
        chk_cnt++; if (brake !== 12'h333) $display("FAIL wdog_brake: got %h want 333", brake); else pass_cnt++;
        resp_drop[4] = 1'b1;
        c0 = conv_cnt;
        wait_wrt(700, n);
        chk_cnt++; if (wrt !== 1'b1 || wt_data !== 16'h2000) $display("FAIL wdog_torque_cmd: got %h want 2000", wt_data); else pass_cnt++;
        n = 0;
        while (timeout !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        chk_cnt++; if (timeout !== 1'b1) $display("FAIL wdog_timeout: got %b want 1", timeout); else pass_cnt++;
        chk_cnt++; if (torque !== 12'h000) $display("FAIL wdog_torque_held: got %h want 000", torque); else pass_cnt++;
        wait_wrt(700, n);
        chk_cnt++; if (wrt !== 1'b1 || wt_data !== 16'h0000) $display("FAIL wdog_next_cmd: got %h want 0000", wt_data); else pass_cnt++;
        chk_cnt++; if (conv_cnt != c0) $display("FAIL wdog_no_conv: got %0d want 0", conv_cnt - c0); else pass_cnt++;
        chk_cnt++; if (timeout !== 1'b1) $display("FAIL wdog_sticky: got %b want 1", timeout); else pass_cnt++;
        resp_drop[4] = 1'b0;
`else
        repeat (50) tick();
        chk_cnt++; if (timeout !== 1'b0) $display("FAIL no_wdog_timeout: got %b want 0", timeout); else pass_cnt++;
`endif
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            resp_data[i] = 16'h0000;
            resp_drop[i] = 1'b0;
        end
        test_reset();
        test_first_conv();
        test_full_round();
        test_en_drop();
        test_rst_mid();
        test_spurious();
        test_watchdog();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sensor_a2d_sched.md
Name: sensor_a2d_sched

Overview:
- Round-robin scheduler that shares one SPI master between the four A2D channels feeding the sensor-conditioning path: battery, current, brake and torque.
- Issues the two-transaction A2D protocol per channel (command, then read) over a wrt/done handshake.
- Holds the latest 12-bit result per channel.
- Pulses conv_cmplt at the end of each full round, so downstream accumulators sample coherent data.

Parameters:
- FAST_SIM, 1, 1 = inter-conversion timer terminal count 2^9-1; 0 = 2^14-1.
- CH_BATT, 3'd0, A2D channel address for battery voltage.
- CH_CURR, 3'd1, A2D channel address for motor current.
- CH_BRAKE, 3'd3, A2D channel address for brake lever.
- CH_TORQUE, 3'd4, A2D channel address for crank torque.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  enable; when low, the scheduler parks in IDLE after finishing any channel in flight.
- done  input  1  SPI master transaction complete; 1-cycle pulse.
- rd_data  input  16  SPI master read data; valid in the done cycle.
- wrt  output  1  start SPI transaction; 1-cycle pulse.
- wt_data  output  16  SPI command word; held stable from wrt until done.
- batt  output  12  latest battery sample.
- curr  output  12  latest current sample.
- brake  output  12  latest brake sample.
- torque  output  12  latest torque sample.
- conv_cmplt  output  1  1-cycle pulse after the torque result is stored.
- all_valid  output  1  sticky; set once every channel has been stored at least once since reset.
- timeout  output  1  sticky watchdog flag; only present when A2D_WDOG_EN is defined, otherwise tied 0.

Behaviour:
- Reset (asynchronous, rst=1), all outputs and state take these values immediately:
  - state=IDLE, channel index=0 (batt), timer=0.
  - wrt=0, wt_data=16'h0000, all sample registers=12'h000.
  - conv_cmplt=0, all_valid=0, timeout=0.
  - Reset mid-transaction abandons the transaction. Any done arriving after reset releases is ignored, because the FSM is in IDLE.
- Timer:
  - 14-bit counter, increments only in IDLE with en=1; holds at 0 while en=0.
  - Terminal count is &cnt[8:0] when FAST_SIM=1, &cnt[13:0] when FAST_SIM=0.
  - At terminal count the FSM leaves IDLE and the timer clears.
- Channel order: batt -> curr -> brake -> torque -> batt. The index is a 2-bit counter that wraps 3->0.
- Command word: {2'b00, CH_x, 11'h000}, driven on wt_data from CMD until the read transaction's done.
- FSM states:
  - IDLE -> CMD on timer terminal count with en=1.
  - CMD: wrt=1 for exactly one cycle -> WAIT_CMD.
  - WAIT_CMD: wait for done; rd_data is discarded -> GAP.
  - GAP: exactly one idle cycle, wrt=0 -> READ.
  - READ: wrt=1 for one cycle, same wt_data -> WAIT_RD.
  - WAIT_RD: on done, store rd_data[11:0] into the current channel's register on that edge; advance the index -> IDLE.
- Latency: with zero-delay done, a channel completes 6 cycles after leaving IDLE.
- conv_cmplt is asserted the cycle after the torque register updates, for one cycle.
- all_valid sets on the same edge conv_cmplt rises, i.e. after the first full round.
- en deassert mid-channel: the channel completes and its result is stored; the FSM then stays in IDLE until en=1. The channel index is retained, so no channel is skipped.
- A done received in IDLE, CMD, GAP or READ is ignored.
- wrt is never asserted while a prior transaction is outstanding.
- Sample registers update only on their own channel's read; the other three hold.

Optional Feature:
- Macro A2D_WDOG_EN.
- Defined:
  - A 10-bit watchdog counts cycles in WAIT_CMD/WAIT_RD and clears on state entry.
  - At 1023 cycles with no done: abort to IDLE, set timeout (sticky until rst), leave the channel register unchanged, advance the index.
  - If the aborted channel was torque, conv_cmplt does not pulse.
- Not defined: no watchdog; the FSM waits indefinitely for done; timeout tied 0.

Test Plan:
- Reset, en=1, FAST_SIM=1, SPI model returns done 20 cycles after wrt with rd_data=16'hFABC on the batt read -> first wrt at cycle 512, wt_data=16'h0000, batt=12'hABC; curr/brake/torque remain 12'h000.
- Full round, model returns channel-tagged data (batt 12'h111, curr 12'h222, brake 12'h333, torque 12'h444) -> command words 16'h0000, 16'h0800, 16'h1800, 16'h2000 in order; single conv_cmplt pulse after torque; all_valid=1; second round starts with batt.
- Drop en during curr WAIT_RD -> curr still stored; no wrt while en=0; on en=1 the next command is brake (16'h1800) after 512 cycles.
- Assert rst for 1 cycle during brake WAIT_CMD, then done arrives -> FSM in IDLE, done ignored, all outputs 0, next command is 16'h0000.
- Spurious done pulse in IDLE and in GAP -> no state change, no register update, exactly one wrt per READ.
- With A2D_WDOG_EN defined, model never answers torque command -> after 1023 cycles timeout=1, torque unchanged, no conv_cmplt, next command 16'h0000.
